hazard_stall_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage, 16-register core.
- It sits beside the forwarding logic and covers the hazards forwarding cannot resolve:
  - load-use dependencies,
  - taken-branch squash,
  - I-cache and D-cache miss waits,
  - halt retirement.
- It drives the per-stage write-enable, flush and bubble controls, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use stalls, branch squash,
// I/D-cache miss waits and halt retirement, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_IDEX,
  input  logic             RegWrite_IDEX,
  input  logic [3:0]       DstReg1_in_from_IDEX,
  input  logic [3:0]       SrcReg1_in_to_IDEX,
  input  logic [3:0]       SrcReg2_in_to_IDEX,
  input  logic             src1_used_ID,
  input  logic             src2_used_ID,
  input  logic             MemWrite_ID,
  input  logic             branch_taken_ID,
  input  logic             icache_miss,
  input  logic             icache_fill_done,
  input  logic             dcache_miss,
  input  logic             dcache_fill_done,
  input  logic             halt_MEMWB,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_write,
  output logic             IDEX_bubble,
  output logic             EXMEM_write,
  output logic             MEMWB_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             imiss_pend_q, imiss_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             src1_hit, src2_hit;

  // Store data (src2 of a store) is served by MEM-to-MEM forwarding, so it never stalls.
  assign src1_hit = src1_used_ID && (DstReg1_in_from_IDEX == SrcReg1_in_to_IDEX);
  assign src2_hit = src2_used_ID && !MemWrite_ID &&
                    (DstReg1_in_from_IDEX == SrcReg2_in_to_IDEX);
  assign load_use = MemRead_IDEX && RegWrite_IDEX &&
                    (DstReg1_in_from_IDEX != 4'd0) && (src1_hit || src2_hit);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_write   = 1'b1;
    IDEX_bubble  = 1'b0;
    EXMEM_write  = 1'b1;
    MEMWB_bubble = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    imiss_pend_d = imiss_pend_q;

    if (rst) begin
      PC_write     = 1'b0;
      IFID_flush   = 1'b1;
      IDEX_bubble  = 1'b1;
      MEMWB_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_MEMWB) begin
            PC_write    = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            state_d     = HALT;
          end else if (dcache_miss) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            MEMWB_bubble = 1'b1;
            state_d      = DMISS;
          end else if (icache_miss) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
            state_d     = IMISS;
          end else if (load_use) begin
            // One bubble suffices: the load moves on to MEM; a pending branch re-evaluates next cycle.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
          end else if (branch_taken_ID) begin
            IFID_flush = 1'b1;
          end
        end

        IMISS: begin
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          IDEX_bubble = 1'b1;
          if (icache_fill_done) begin
            state_d = RUN;
          end else if (dcache_miss) begin
            state_d      = DMISS;
            imiss_pend_d = 1'b1;
          end
        end

        DMISS: begin
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          IDEX_write   = 1'b0;
          EXMEM_write  = 1'b0;
          MEMWB_bubble = 1'b1;
          if (icache_fill_done) begin
            imiss_pend_d = 1'b0;
          end
          if (dcache_fill_done) begin
            // Resume the interrupted I-fetch wait only if its fill has not landed meanwhile.
            state_d      = imiss_pend_d ? IMISS : RUN;
            imiss_pend_d = 1'b0;
          end
        end

        HALT: begin
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          IDEX_write   = 1'b0;
          EXMEM_write  = 1'b0;
          MEMWB_bubble = 1'b1;
          halted       = 1'b1;
        end

        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALT) && !PC_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      imiss_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      imiss_pend_q <= imiss_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
